ex_muldiv: RTL and testbench

//  Multi-cycle multiply/divide execution unit beside the single-cycle EX ALU.

---
 rtl/ex_muldiv.sv | 203 ++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : ex_muldiv
// Purpose : Iterative (1 bit/cycle) signed/unsigned multiply/divide unit that
//           owns HI/LO and holds the pipeline while busy.
//           Optional MULDIV_ACC_EN adds MADD/MADDU/MSUB/MSUBU accumulation.
// Revision: 1.0 - initial release
// ============================================================================
module ex_muldiv #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  input  logic              annul_i,
  output logic              stall_req_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              dbz_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W-1:0] r_p;
  logic [DATA_W-1:0]   r_m;
  logic                r_neg, r_rneg, r_div, r_dbz;
  logic                r_done, r_dbz_o;
  logic [DATA_W-1:0]   r_hi, r_lo;
`ifdef MULDIV_ACC_EN
  logic                r_acc, r_sub;
`endif

  logic w_op_ok, w_accept, w_is_div, w_dbz, w_signed, w_sa, w_sb;
  logic w_busy, w_stall;
  logic [DATA_W-1:0]   w_mag_a, w_mag_b;
  logic [DATA_W:0]     w_mul_sum, w_div_sh;
  logic [DATA_W-1:0]   w_div_diff;
  logic                w_div_ge;
  logic [2*DATA_W-1:0] w_mul_step, w_div_step, w_prod, w_result;
  logic [DATA_W-1:0]   w_q, w_r;

`ifdef MULDIV_ACC_EN
  assign w_op_ok = 1'b1;
`else
  assign w_op_ok = ~op_i[2];
`endif

  // Accumulate ops (1xx) always run through the multiplier, even MSUB (op[1]=1).
  assign w_is_div = ~op_i[2] & op_i[1];
  assign w_dbz    = (opb_i == '0);
  assign w_signed = ~op_i[0];
  assign w_sa     = w_signed & opa_i[DATA_W-1];
  assign w_sb     = w_signed & opb_i[DATA_W-1];
  assign w_mag_a  = w_sa ? -opa_i : opa_i;
  assign w_mag_b  = w_sb ? -opb_i : opb_i;
  assign w_accept = (r_state == S_IDLE) & start_i & ~annul_i & w_op_ok;

  assign w_mul_sum  = {1'b0, r_p[2*DATA_W-1:DATA_W]}
                    + (r_p[0] ? {1'b0, r_m} : {(DATA_W+1){1'b0}});
  assign w_mul_step = {w_mul_sum, r_p[DATA_W-1:1]};

  assign w_div_sh   = r_p[2*DATA_W-1:DATA_W-1];
  assign w_div_ge   = (w_div_sh >= {1'b0, r_m});
  assign w_div_diff = w_div_sh[DATA_W-1:0] - r_m;
  assign w_div_step = {(w_div_ge ? w_div_diff : w_div_sh[DATA_W-1:0]),
                       r_p[DATA_W-2:0], w_div_ge};

  // Sign correction; -MIN wraps back to MIN, which gives the MIN/-1 result.
  assign w_prod = r_neg  ? -r_p : r_p;
  assign w_q    = r_neg  ? -r_p[DATA_W-1:0] : r_p[DATA_W-1:0];
  assign w_r    = r_rneg ? -r_p[2*DATA_W-1:DATA_W] : r_p[2*DATA_W-1:DATA_W];

  always_comb begin
    w_result = w_prod;
    if (r_dbz)
      w_result = r_p;
    else if (r_div)
      w_result = {w_r, w_q};
`ifdef MULDIV_ACC_EN
    else if (r_acc)
      w_result = r_sub ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_busy  = 1'b0;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_accept;
        if (w_accept)
          w_next = w_is_div ? (w_dbz ? S_DONE : S_DIV) : S_MUL;
      end
      S_MUL, S_DIV: begin
        w_busy  = 1'b1;
        w_stall = 1'b1;
        if (r_cnt == C_LAST)
          w_next = S_DONE;
      end
      S_DONE: begin
        w_stall = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (annul_i)
      w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_p     <= '0;
      r_m     <= '0;
      r_neg   <= 1'b0;
      r_rneg  <= 1'b0;
      r_div   <= 1'b0;
      r_dbz   <= 1'b0;
      r_done  <= 1'b0;
      r_dbz_o <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
`ifdef MULDIV_ACC_EN
      r_acc   <= 1'b0;
      r_sub   <= 1'b0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_dbz_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt  <= '0;
            r_neg  <= w_sa ^ w_sb;
            r_rneg <= w_sa;
            r_div  <= w_is_div;
            r_dbz  <= w_is_div & w_dbz;
`ifdef MULDIV_ACC_EN
            r_acc  <= op_i[2];
            r_sub  <= op_i[1];
`endif
            if (w_is_div) begin
              r_m <= w_mag_b;
              r_p <= w_dbz ? {opa_i, {DATA_W{1'b1}}} : {{DATA_W{1'b0}}, w_mag_a};
            end else begin
              r_m <= w_mag_a;
              r_p <= {{DATA_W{1'b0}}, w_mag_b};
            end
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt + 1'b1;
          r_p   <= w_mul_step;
        end
        S_DIV: begin
          r_cnt <= r_cnt + 1'b1;
          r_p   <= w_div_step;
        end
        S_DONE: begin
          if (!annul_i) begin
            r_done       <= 1'b1;
            r_dbz_o      <= r_dbz;
            {r_hi, r_lo} <= w_result;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_req_o = w_stall;
  assign busy_o      = w_busy;
  assign done_o      = r_done;
  assign dbz_o       = r_dbz_o;
  assign hi_o        = r_hi;
  assign lo_o        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : tb_ex_muldiv
// Purpose : Scoreboard bench for ex_muldiv with directed hand-computed vectors
//           (accumulate ops exercised when MULDIV_ACC_EN is defined).
// Revision: 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;
  localparam int W = 32;
  localparam logic [2:0] C_MULT = 3'b000, C_MULTU = 3'b001, C_DIV = 3'b010,
                         C_DIVU = 3'b011, C_MADD = 3'b100, C_MSUB = 3'b110,
                         C_MSUBU = 3'b111;

  logic         clk = 1'b0, rst = 1'b0, start_i = 1'b0, annul_i = 1'b0;
  logic [2:0]   op_i = 3'b0;
  logic [W-1:0] opa_i = '0, opb_i = '0;
  logic         stall_req_o, busy_o, done_o, dbz_o;
  logic [W-1:0] hi_o, lo_o;

  ex_muldiv #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .opa_i(opa_i),
    .opb_i(opb_i), .annul_i(annul_i), .stall_req_o(stall_req_o),
    .busy_o(busy_o), .done_o(done_o), .dbz_o(dbz_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0, errors = 0;
  int   lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dbz);
    sb.push_back('{hi: hi, lo: lo, dbz: dbz});
  endtask

  // Returns #1 after the accepting edge; operands are scrambled to prove they are held.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    op_i = op; opa_i = a; opb_i = b; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0; opa_i = ~a; opb_i = ~b;
  endtask

  // lat = clock edges after the accepting edge until done_o is seen.
  task automatic wait_done(output int l);
    l = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_o) begin
        l = i;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL done_timeout: got no done_o expected done_o within 100 cycles");
  endtask

  always @(negedge clk) begin
    if (rst && done_o) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done_o=1 expected no pending result");
      end else begin
        mon_e = sb.pop_front();
        chk("sb_hi",  hi_o,  mon_e.hi);
        chk("sb_lo",  lo_o,  mon_e.lo);
        chk("sb_dbz", dbz_o, mon_e.dbz);
      end
    end
  end

  initial begin
    #1;
    chk("rst_hi", hi_o, 0); chk("rst_lo", lo_o, 0); chk("rst_done", done_o, 0);
    chk("rst_busy", busy_o, 0); chk("rst_stall", stall_req_o, 0); chk("rst_dbz", dbz_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Signed multiply, latency and issue-cycle stall
    push(32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    @(negedge clk);
    op_i = C_MULT; opa_i = 32'hFFFF_FFFE; opb_i = 32'h3; start_i = 1'b1;
    #1 chk("issue_stall", stall_req_o, 1);
    @(posedge clk);
    #1 start_i = 1'b0; opa_i = '0; opb_i = '0;
    chk("mul_busy", busy_o, 1);
    wait_done(lat);
    chk("mul_latency", lat, W + 1);

    push(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    issue(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(lat);

    push(32'd2, 32'd14, 1'b0);
    issue(C_DIVU, 32'd100, 32'd7); wait_done(lat);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(C_DIV, -32'sd7, 32'd2); wait_done(lat);
    push(32'd1, 32'hFFFF_FFFD, 1'b0);
    issue(C_DIV, 32'd7, -32'sd2); wait_done(lat);
    push(32'd0, 32'h8000_0000, 1'b0);
    issue(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(lat);
    chk("div_latency", lat, W + 1);

    // Divide by zero: DONE straight from IDLE, done_o in the following cycle
    push(32'd5, 32'hFFFF_FFFF, 1'b1);
    issue(C_DIVU, 32'd5, 32'd0); wait_done(lat);
    chk("dbz_latency", lat, 1);

    // Annul mid-multiply: HI/LO stay 5 / all-ones
    issue(C_MULTU, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    @(negedge clk); annul_i = 1'b1;
    @(posedge clk); #1 annul_i = 1'b0;
    chk("annul_stall", stall_req_o, 0); chk("annul_busy", busy_o, 0);
    repeat (40) @(negedge clk);
    chk("annul_hi", hi_o, 32'd5); chk("annul_lo", lo_o, 32'hFFFF_FFFF);

    // Annul together with start
    @(negedge clk);
    op_i = C_MULTU; opa_i = 32'd3; opb_i = 32'd4; start_i = 1'b1; annul_i = 1'b1;
    #1 chk("annul_start_stall", stall_req_o, 0);
    @(posedge clk); #1 start_i = 1'b0; annul_i = 1'b0;
    chk("annul_start_busy", busy_o, 0);
    repeat (40) @(negedge clk);

    // Annul while in DONE: no write
    issue(C_DIVU, 32'd9, 32'd0);
    annul_i = 1'b1;
    chk("done_stall", stall_req_o, 1);
    @(posedge clk); #1 annul_i = 1'b0;
    @(negedge clk);
    chk("done_annul_pulse", done_o, 0);
    repeat (5) @(negedge clk);
    chk("done_annul_hi", hi_o, 32'd5); chk("done_annul_lo", lo_o, 32'hFFFF_FFFF);

    // Asynchronous reset mid-divide
    issue(C_DIVU, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1 chk("arst_hi", hi_o, 0); chk("arst_lo", lo_o, 0);
    chk("arst_busy", busy_o, 0); chk("arst_stall", stall_req_o, 0);
    @(negedge clk); rst = 1'b1;

    // start_i held high through DIV and DONE must be ignored
    push(32'd2, 32'd14, 1'b0);
    issue(C_DIVU, 32'd100, 32'd7);
    op_i = C_MULTU; opa_i = 32'd2; opb_i = 32'd2; start_i = 1'b1;
    for (int i = 1; i <= W + 1; i++) begin
      @(posedge clk);
      if (i == 16) begin
        #1 chk("hold_busy", busy_o, 1);
      end
    end
    #1 start_i = 1'b0;
    @(negedge clk);
    chk("hold_done", done_o, 1);
    repeat (40) @(negedge clk);
    chk("hold_idle", busy_o, 0);

`ifdef MULDIV_ACC_EN
    push(32'd0, 32'd10, 1'b0);
    issue(C_MULTU, 32'd2, 32'd5); wait_done(lat);
    push(32'd0, 32'd16, 1'b0);
    issue(C_MADD, 32'd2, 32'd3); wait_done(lat);
    push(32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b0);
    issue(C_MSUBU, 32'd5, 32'd5); wait_done(lat);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(C_MSUB, 32'hFFFF_FFFE, 32'd3); wait_done(lat);
`else
    @(negedge clk);
    op_i = C_MADD; opa_i = 32'd2; opb_i = 32'd3; start_i = 1'b1;
    #1 chk("noacc_stall", stall_req_o, 0);
    @(posedge clk); #1 start_i = 1'b0;
    chk("noacc_busy", busy_o, 0);
    repeat (40) @(negedge clk);
    chk("noacc_hi", hi_o, 32'd2); chk("noacc_lo", lo_o, 32'd14);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
